// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core:
// forwarding, load-use and branch handling, and the data-memory wait FSM.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  input  logic       pc_src_e,
  input  logic [4:0] rd_m,
  input  logic       reg_w_m,
  input  logic [1:0] result_src_m,
  input  logic       mem_w_m,
  input  logic [4:0] rd_w,
  input  logic       reg_w_w,
  input  logic       dmem_ready,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic       dmem_req,
  output logic       mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  logic halt;
  logic mem_acc;
  logic mem_stall;
  logic lw_stall;
  logic br_flush;
  logic lu_stall;

  function automatic logic [1:0] fwd(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wm,
    input logic [4:0] rdw,
    input logic       ww
  );
    if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign forward_a_e = fwd(rs1_e, rd_m, reg_w_m,
                           rd_w, reg_w_w);
  assign forward_b_e = fwd(rs2_e, rd_m, reg_w_m,
                           rd_w, reg_w_w);

  assign halt      = (state_q == HALT);
  assign mem_acc   = mem_w_m | (result_src_m == 2'b01);
  assign mem_stall = mem_acc & ~dmem_ready & ~halt;
  assign lw_stall  = (result_src_e == 2'b01)
                   & (rd_e != 5'd0)
                   & ((rd_e == rs1_d) | (rd_e == rs2_d))
                   & ~pc_src_e;

  // Mutually exclusive controls in priority order.
  assign br_flush = pc_src_e & ~halt & ~mem_stall;
  assign lu_stall = lw_stall & ~halt & ~mem_stall;

  assign dmem_req = mem_acc & ~halt;
  assign mem_err  = err_q;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    unique case (1'b1)
      halt: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end
      mem_stall: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end
      br_flush: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      lu_stall: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_acc && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= (state_d == HALT);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
// Control vector layout: {sf,sd,se,sm,fd,fe,fw,req,err}.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
  logic [1:0] result_src_e;
  logic       pc_src_e;
  logic [4:0] rd_m;
  logic       reg_w_m;
  logic [1:0] result_src_m;
  logic       mem_w_m;
  logic [4:0] rd_w;
  logic       reg_w_w;
  logic       dmem_ready;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic       dmem_req, mem_err;

  int n_chk;
  int n_fail;

  localparam logic [8:0] C_ZERO = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110001000;
  localparam logic [8:0] C_BR   = 9'b000011000;
  localparam logic [8:0] C_MST  = 9'b111100110;
  localparam logic [8:0] C_BRRQ = 9'b000011010;
  localparam logic [8:0] C_REQ  = 9'b000000010;
  localparam logic [8:0] C_HALT = 9'b111100001;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .result_src_e(result_src_e),
    .pc_src_e    (pc_src_e),
    .rd_m        (rd_m),
    .reg_w_m     (reg_w_m),
    .result_src_m(result_src_m),
    .mem_w_m     (mem_w_m),
    .rd_w        (rd_w),
    .reg_w_w     (reg_w_w),
    .dmem_ready  (dmem_ready),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_w     (flush_w),
    .dmem_req    (dmem_req),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [8:0] got,
    input logic [8:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_w,
            dmem_req, mem_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; result_src_e = 0; pc_src_e = 0;
    rd_m = 0; reg_w_m = 0; result_src_m = 0;
    mem_w_m = 0; rd_w = 0; reg_w_w = 0;
    dmem_ready = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr();
    rst_n = 1'b0;
    #12;
    check("reset_ctl", ctl(), C_ZERO);
    check("reset_fa", 9'(forward_a_e), 9'd0);
    check("reset_fb", 9'(forward_b_e), 9'd0);
    cyc();
    rst_n = 1'b1;

    // Forwarding
    cyc();
    rd_m = 5; rd_w = 5; rs1_e = 5; rs2_e = 5;
    reg_w_m = 1; reg_w_w = 1;
    #1;
    check("fwd_m_prio_a", 9'(forward_a_e), 9'd2);
    check("fwd_m_prio_b", 9'(forward_b_e), 9'd2);
    reg_w_m = 0;
    #1;
    check("fwd_w_a", 9'(forward_a_e), 9'd1);
    rd_m = 0; reg_w_m = 1; rd_w = 0;
    #1;
    check("fwd_x0", 9'(forward_a_e), 9'd0);
    rd_w = 5; rs2_e = 6;
    #1;
    check("fwd_m0_w", 9'(forward_a_e), 9'd1);
    check("fwd_b_none", 9'(forward_b_e), 9'd0);
    check("fwd_ctl_quiet", ctl(), C_ZERO);

    // Load-use: one bubble
    cyc();
    clr();
    result_src_e = 2'b01; rd_e = 3; rs2_d = 3;
    #1;
    check("lu_stall", ctl(), C_LU);
    cyc();
    result_src_e = 2'b00; rd_e = 0;
    #1;
    check("lu_release", ctl(), C_ZERO);
    result_src_e = 2'b01; rd_e = 0; rs2_d = 0;
    #1;
    check("lu_x0", ctl(), C_ZERO);

    // Branch beats load-use
    cyc();
    clr();
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7;
    pc_src_e = 1;
    #1;
    check("br_over_lu", ctl(), C_BR);

    // Memory wait with pending branch
    cyc();
    clr();
    result_src_m = 2'b01; pc_src_e = 1;
    #1;
    check("mw_idle", ctl(), C_MST);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("mw_wait", ctl(), C_MST);
    end
    cyc();
    dmem_ready = 1;
    #1;
    check("mw_release_br", ctl(), C_BRRQ);
    cyc();
    clr();
    #1;
    check("mw_after", ctl(), C_ZERO);
    mem_w_m = 1; dmem_ready = 1;
    #1;
    check("zero_wait", ctl(), C_REQ);
    cyc();
    mem_w_m = 0; dmem_ready = 1;
    #1;
    check("ready_ignored", ctl(), C_ZERO);

    // Timeout: 5 stalled cycles then HALT
    cyc();
    clr();
    mem_w_m = 1;
    #1;
    check("to_stall0", ctl(), C_MST);
    for (int i = 1; i < 5; i++) begin
      cyc();
      check("to_stall", ctl(), C_MST);
    end
    cyc();
    check("to_halt", ctl(), C_HALT);
    cyc();
    mem_w_m = 0;
    #1;
    check("halt_sticky", ctl(), C_HALT);
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_async_rst", ctl(), C_ZERO);
    cyc();
    rst_n = 1'b1;

    // Reset in the second WAIT cycle
    cyc();
    mem_w_m = 1;
    #1;
    check("rw_idle", ctl(), C_MST);
    cyc();
    cyc();
    check("rw_wait2", ctl(), C_MST);
    clr();
    rst_n = 1'b0;
    #1;
    check("rw_rst", ctl(), C_ZERO);
    cyc();
    rst_n = 1'b1;
    cyc();
    mem_w_m = 1;
    #1;
    check("rw_restart", ctl(), C_MST);
    for (int i = 1; i < 5; i++) begin
      cyc();
      check("rw_restart_st", ctl(), C_MST);
    end
    cyc();
    check("rw_full_tmo", ctl(), C_HALT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
